// File: rtl/hiscore_pkg.sv
// Shared types and widths for the hiscore work-RAM arbiter and its port mux.
package hiscore_pkg;

  // Arbiter FSM encoding; values are visible on the debug state output.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAUSE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_OWN     = 3'd3,
    ST_RELEASE = 3'd4
  } arb_state_t;

  localparam int HS_DATA_W   = 8;
  localparam int HS_WDOG_W   = 16;
  localparam int HS_SETTLE_W = 8;

endpackage

// File: rtl/hs_port_mux.sv
// Combinational CPU/engine RAM port mux with a write-suppress input.
// The select is expected to come straight from registered state so the
// muxed address/data/we never glitch between owners.
module hs_port_mux
  import hiscore_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic                 i_sel_eng,
  input  logic                 i_force_we_off,
  input  logic [AW-1:0]        i_cpu_addr,
  input  logic [HS_DATA_W-1:0] i_cpu_wdata,
  input  logic                 i_cpu_we,
  input  logic [AW-1:0]        i_eng_addr,
  input  logic [HS_DATA_W-1:0] i_eng_wdata,
  input  logic                 i_eng_we,
  output logic [AW-1:0]        o_addr,
  output logic [HS_DATA_W-1:0] o_wdata,
  output logic                 o_we
);

  // Pick the owner's address/data/we, then apply the write suppression last.
  always_comb begin
    o_addr  = i_cpu_addr;
    o_wdata = i_cpu_wdata;
    o_we    = i_cpu_we;
    if (i_sel_eng) begin
      o_addr  = i_eng_addr;
      o_wdata = i_eng_wdata;
      o_we    = i_eng_we;
    end
    if (i_force_we_off) begin
      o_we = 1'b0;
    end
  end

endmodule

// File: rtl/hiscore_ram_arbiter.sv
// Shares the game work-RAM port between the CPU and the hiscore engine.
//
// Request/grant handshake: the engine holds hs_req high for as long as it
// wants the port. hs_grant rises only after the CPU has been paused, has
// reached a bus boundary (cpu_idle) and a settle window has elapsed; while
// hs_grant=1 the engine's address/data/we drive the RAM. Dropping hs_req
// (or the watchdog expiring) ends ownership: hs_grant falls, one
// write-suppressed RELEASE cycle follows, then the CPU is unpaused.
// After a watchdog release the engine is locked out until hs_req is seen low.
module hiscore_ram_arbiter
  import hiscore_pkg::*;
#(
  parameter int ADDRESSWIDTH  = 10,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_HOLD      = 1023
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDRESSWIDTH-1:0] cpu_addr,
  input  logic [HS_DATA_W-1:0]    cpu_wdata,
  input  logic                    cpu_we,
  output logic [HS_DATA_W-1:0]    cpu_rdata,
  input  logic                    cpu_idle,
  input  logic                    hs_req,
  input  logic [ADDRESSWIDTH-1:0] hs_addr,
  input  logic [HS_DATA_W-1:0]    hs_wdata,
  input  logic                    hs_we,
  output logic                    hs_grant,
  output logic [HS_DATA_W-1:0]    hs_rdata,
  output logic [ADDRESSWIDTH-1:0] ram_addr,
  output logic [HS_DATA_W-1:0]    ram_wdata,
  output logic                    ram_we,
  input  logic [HS_DATA_W-1:0]    ram_rdata,
  output logic                    pause_cpu,
  output logic                    timeout,
  output logic [2:0]              dbg_state
);

  localparam logic [HS_SETTLE_W-1:0] SETTLE_LOAD = HS_SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [HS_WDOG_W-1:0]   WDOG_LAST   = HS_WDOG_W'(MAX_HOLD - 1);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic                   r_pause_cpu;
  logic                   w_pause_nxt;
  logic                   r_hs_grant;
  logic                   w_grant_nxt;
  logic                   r_timeout;
  logic                   w_timeout_nxt;
  logic                   r_lockout;
  logic                   w_lockout_nxt;
  logic [HS_SETTLE_W-1:0] r_settle_cnt;
  logic [HS_SETTLE_W-1:0] w_settle_nxt;
  logic [HS_WDOG_W-1:0]   r_wdog_cnt;
  logic [HS_WDOG_W-1:0]   w_wdog_nxt;
  logic [HS_DATA_W-1:0]   r_hs_rdata;
  logic                   w_sel_eng;
  logic                   w_we_off;

  // State and registered control outputs; reset hands the port to the CPU at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_pause_cpu  <= 1'b0;
      r_hs_grant   <= 1'b0;
      r_timeout    <= 1'b0;
      r_lockout    <= 1'b0;
      r_settle_cnt <= '0;
      r_wdog_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pause_cpu  <= w_pause_nxt;
      r_hs_grant   <= w_grant_nxt;
      r_timeout    <= w_timeout_nxt;
      r_lockout    <= w_lockout_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_wdog_cnt   <= w_wdog_nxt;
    end
  end

  // Engine read data is captured only while the engine owns the port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_rdata <= '0;
    end else if (r_state == ST_OWN) begin
      r_hs_rdata <= ram_rdata;
    end
  end

  // Next-state and next-output decode. A request drop always beats any other
  // event in the same cycle, so a drop at watchdog expiry is a normal release.
  always_comb begin
    w_state_nxt   = r_state;
    w_pause_nxt   = r_pause_cpu;
    w_grant_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;
    w_lockout_nxt = r_lockout & hs_req;
    w_settle_nxt  = r_settle_cnt;
    w_wdog_nxt    = '0;
    case (r_state)
      ST_IDLE: begin
        w_pause_nxt = 1'b0;
        if (hs_req && !r_lockout) begin
          w_state_nxt = ST_PAUSE;
          w_pause_nxt = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (!hs_req) begin
          w_state_nxt = ST_RELEASE;
        end else if (cpu_idle) begin
          w_state_nxt  = ST_SETTLE;
          w_settle_nxt = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (!hs_req) begin
          w_state_nxt = ST_RELEASE;
        end else if (r_settle_cnt == '0) begin
          w_state_nxt = ST_OWN;
          w_grant_nxt = 1'b1;
        end else begin
          w_settle_nxt = r_settle_cnt - 1'b1;
        end
      end
      ST_OWN: begin
        if (!hs_req) begin
          w_state_nxt = ST_RELEASE;
        end else if (r_wdog_cnt == WDOG_LAST) begin
          w_state_nxt   = ST_RELEASE;
          w_timeout_nxt = 1'b1;
          w_lockout_nxt = 1'b1;
        end else begin
          w_grant_nxt = 1'b1;
          w_wdog_nxt  = r_wdog_cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
        w_pause_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pause_nxt = 1'b0;
      end
    endcase
  end

  // Mux controls come from the state register only, never from inputs.
  always_comb begin
    w_sel_eng = (r_state == ST_OWN);
    w_we_off  = (r_state == ST_SETTLE) || (r_state == ST_RELEASE);
  end

  hs_port_mux #(
    .AW(ADDRESSWIDTH)
  ) u_mux (
    .i_sel_eng      (w_sel_eng),
    .i_force_we_off (w_we_off),
    .i_cpu_addr     (cpu_addr),
    .i_cpu_wdata    (cpu_wdata),
    .i_cpu_we       (cpu_we),
    .i_eng_addr     (hs_addr),
    .i_eng_wdata    (hs_wdata),
    .i_eng_we       (hs_we),
    .o_addr         (ram_addr),
    .o_wdata        (ram_wdata),
    .o_we           (ram_we)
  );

  assign cpu_rdata = ram_rdata;
  assign hs_grant  = r_hs_grant;
  assign hs_rdata  = r_hs_rdata;
  assign pause_cpu = r_pause_cpu;
  assign timeout   = r_timeout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Bench for hiscore_ram_arbiter: randomized engine sessions against a
// phase-level reference model and a RAM content model.
module tb_hiscore_ram_arbiter;

  localparam int AW     = 10;
  localparam int SETTLE = 4;
  localparam int MAXH   = 16;

  // Phases of an engine session as seen from outside (numbers match the
  // published state encoding).
  localparam int P_IDLE   = 0;
  localparam int P_PAUSE  = 1;
  localparam int P_SETTLE = 2;
  localparam int P_OWN    = 3;
  localparam int P_REL    = 4;

  localparam logic [2:0] K_GRANT = 3'd0;
  localparam logic [2:0] K_PAUSE = 3'd1;
  localparam logic [2:0] K_WE    = 3'd2;
  localparam logic [2:0] K_ADDR  = 3'd3;
  localparam logic [2:0] K_WDATA = 3'd4;
  localparam logic [2:0] K_RDATA = 3'd5;
  localparam logic [2:0] K_TO    = 3'd6;
  localparam logic [2:0] K_STATE = 3'd7;

  typedef struct packed {
    logic [31:0] due;
    logic [2:0]  kind;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_we;
  logic [7:0]    cpu_rdata;
  logic          cpu_idle;
  logic          hs_req;
  logic [AW-1:0] hs_addr;
  logic [7:0]    hs_wdata;
  logic          hs_we;
  logic          hs_grant;
  logic [7:0]    hs_rdata;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_rdata;
  logic          pause_cpu;
  logic          timeout;
  logic [2:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] ram_m[1024];
  logic [7:0] ref_mem[1024];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  hiscore_ram_arbiter #(
    .ADDRESSWIDTH (AW),
    .SETTLE_CYCLES(SETTLE),
    .MAX_HOLD     (MAXH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_we   (cpu_we),
    .cpu_rdata(cpu_rdata),
    .cpu_idle (cpu_idle),
    .hs_req   (hs_req),
    .hs_addr  (hs_addr),
    .hs_wdata (hs_wdata),
    .hs_we    (hs_we),
    .hs_grant (hs_grant),
    .hs_rdata (hs_rdata),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we   (ram_we),
    .ram_rdata(ram_rdata),
    .pause_cpu(pause_cpu),
    .timeout  (timeout),
    .dbg_state(dbg_state)
  );

  // Synchronous work RAM, read-before-write, one cycle read latency.
  always @(posedge clk) begin
    if (ram_we) ram_m[ram_addr] <= ram_wdata;
    ram_rdata <= ram_m[ram_addr];
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_m[i]   = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
  end

  // ---------------- scoreboard ----------------
  function automatic string kname(input logic [2:0] k);
    case (k)
      K_GRANT: return "hs_grant";
      K_PAUSE: return "pause_cpu";
      K_WE:    return "ram_we";
      K_ADDR:  return "ram_addr";
      K_WDATA: return "ram_wdata";
      K_RDATA: return "hs_rdata";
      K_TO:    return "timeout";
      default: return "state";
    endcase
  endfunction

  task automatic push(input int due, input logic [2:0] kind, input logic [15:0] val);
    exp_t e;
    e.due  = 32'(due);
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: compares every expectation due in the current cycle, mid-cycle.
  always @(negedge clk) begin
    logic [15:0] act;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].due == 32'(cyc)) begin
        case (exp_q[i].kind)
          K_GRANT: act = 16'(hs_grant);
          K_PAUSE: act = 16'(pause_cpu);
          K_WE:    act = 16'(ram_we);
          K_ADDR:  act = 16'(ram_addr);
          K_WDATA: act = 16'(ram_wdata);
          K_RDATA: act = 16'(hs_rdata);
          K_TO:    act = 16'(timeout);
          default: act = 16'(dbg_state);
        endcase
        n_vec++;
        if (act !== exp_q[i].val) begin
          n_err++;
          $display("FAIL %s cyc=%0d: got %h expected %h", kname(exp_q[i].kind), cyc, act, exp_q[i].val);
        end
        exp_q.delete(i);
      end else if (exp_q[i].due < 32'(cyc)) begin
        n_vec++;
        n_err++;
        $display("FAIL stale_%s due=%0d cyc=%0d", kname(exp_q[i].kind), exp_q[i].due, cyc);
        exp_q.delete(i);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus and record what the outside world should see
  // in that phase. The engine's inputs are randomized outside OWN to show
  // they are ignored there.
  task automatic drv(input int ph, input bit req, input bit idle, input bit ewe,
                     input logic [AW-1:0] eaddr, input logic [7:0] ewd,
                     input bit rd_chk, input bit exp_to);
    int c;
    c         = cyc;
    hs_req    = req;
    cpu_idle  = idle;
    cpu_addr  = AW'($urandom_range(0, 255));
    cpu_wdata = 8'($urandom);
    cpu_we    = 1'($urandom_range(0, 1));
    if (ph == P_OWN) begin
      hs_we    = ewe;
      hs_addr  = eaddr;
      hs_wdata = ewd;
    end else begin
      hs_we    = 1'($urandom_range(0, 1));
      hs_addr  = AW'($urandom_range(256, 1023));
      hs_wdata = 8'($urandom);
    end
    push(c, K_STATE, 16'(ph));
    push(c, K_TO,    16'(exp_to));
    push(c, K_GRANT, 16'(ph == P_OWN));
    push(c, K_PAUSE, 16'(ph != P_IDLE));
    case (ph)
      P_IDLE, P_PAUSE: begin
        push(c, K_WE,    16'(cpu_we));
        push(c, K_ADDR,  16'(cpu_addr));
        push(c, K_WDATA, 16'(cpu_wdata));
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      end
      P_SETTLE, P_REL: begin
        push(c, K_WE,   16'd0);
        push(c, K_ADDR, 16'(cpu_addr));
      end
      default: begin
        push(c, K_WE,   16'(ewe));
        push(c, K_ADDR, 16'(eaddr));
        if (ewe) begin
          push(c, K_WDATA, 16'(ewd));
          ref_mem[eaddr] = ewd;
        end else if (rd_chk) begin
          push(c + 2, K_RDATA, 16'(ref_mem[eaddr]));
        end
      end
    endcase
  endtask

  task automatic idle_cycle();
    step();
    drv(P_IDLE, 1'b0, 1'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // One engine session. mode: 0 normal release after n_own requesting OWN
  // cycles, 1 watchdog expiry, 2 drop in SETTLE cycle abort_at, 3 drop in
  // PAUSE cycle abort_at (with cpu_idle=1 in the same cycle).
  task automatic run_session(input int mode, input int idle_wait, input int n_own,
                             input int abort_at, input bit directed);
    bit aborted;
    int own_cycles;
    bit we;
    logic [AW-1:0] a;
    logic [7:0] d;
    aborted = 1'b0;
    step();
    drv(P_IDLE, 1'b1, 1'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i <= idle_wait; i++) begin
      step();
      if (mode == 3 && i == abort_at) begin
        drv(P_PAUSE, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        aborted = 1'b1;
        break;
      end
      drv(P_PAUSE, 1'b1, (i == idle_wait), 1'b0, '0, '0, 1'b0, 1'b0);
    end
    if (!aborted) begin
      for (int j = 0; j < SETTLE; j++) begin
        step();
        if (mode == 2 && j == abort_at) begin
          drv(P_SETTLE, 1'b0, 1'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0, 1'b0);
          aborted = 1'b1;
          break;
        end
        drv(P_SETTLE, 1'b1, 1'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0, 1'b0);
      end
    end
    if (!aborted) begin
      own_cycles = (mode == 1) ? MAXH : n_own;
      for (int k = 0; k < own_cycles; k++) begin
        we = 1'($urandom_range(0, 1));
        a  = $urandom_range(0, 1) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(768, 1023));
        d  = 8'($urandom);
        if (directed && k == 0) begin
          we = 1'b1;
          a  = 10'h3FF;
          d  = 8'hA5;
        end
        if (directed && k == 1) begin
          we = 1'b0;
          a  = 10'h3FF;
        end
        step();
        drv(P_OWN, 1'b1, 1'($urandom_range(0, 1)), we, a, d,
            (mode == 0) || (k < own_cycles - 1), 1'b0);
      end
      if (mode == 0) begin
        step();
        drv(P_OWN, 1'b0, 1'b1, 1'b0, AW'($urandom_range(768, 1023)), 8'h00, 1'b0, 1'b0);
      end
    end
    step();
    drv(P_REL, (mode == 1), 1'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0, (mode == 1));
    if (mode == 1) begin
      for (int i = 0; i < 3; i++) begin
        step();
        drv(P_IDLE, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      end
    end
    idle_cycle();
    repeat ($urandom_range(0, 2)) idle_cycle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int md, iw, no, ab;
    reset_n   = 1'b0;
    cpu_addr  = 10'h015;
    cpu_wdata = 8'h3C;
    cpu_we    = 1'b1;
    cpu_idle  = 1'b0;
    hs_req    = 1'b0;
    hs_addr   = 10'h3A0;
    hs_wdata  = 8'h00;
    hs_we     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant",   16'(hs_grant),  16'd0);
    chk("rst_pause",   16'(pause_cpu), 16'd0);
    chk("rst_timeout", 16'(timeout),   16'd0);
    chk("rst_rdata",   16'(hs_rdata),  16'd0);
    chk("rst_state",   16'(dbg_state), 16'd0);
    chk("rst_addr",    16'(ram_addr),  16'h015);
    cpu_we = 1'b0;
    reset_n = 1'b1;
    repeat (2) idle_cycle();

    run_session(0, 0, 6, 0, 1'b1);   // basic grant + 0x3FF write/readback
    run_session(0, 20, 3, 0, 1'b0);  // long wait for bus boundary
    run_session(1, 1, 0, 0, 1'b0);   // watchdog expiry and lockout
    run_session(2, 0, 0, 1, 1'b0);   // drop during SETTLE
    run_session(3, 2, 0, 2, 1'b0);   // drop together with cpu_idle in PAUSE
    run_session(0, 0, MAXH - 1, 0, 1'b0); // drop exactly at watchdog expiry
    for (int s = 0; s < 24; s++) begin
      md = $urandom_range(0, 3);
      iw = $urandom_range(0, 5);
      no = $urandom_range(1, MAXH - 1);
      ab = (md == 2) ? $urandom_range(0, SETTLE - 1) : $urandom_range(0, iw);
      run_session(md, iw, no, ab, 1'b0);
    end
    repeat (4) idle_cycle();

    // Asynchronous reset while the engine is writing.
    step();
    drv(P_IDLE, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    drv(P_PAUSE, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int j = 0; j < SETTLE; j++) begin
      step();
      drv(P_SETTLE, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    end
    step();
    hs_req    = 1'b1;
    hs_we     = 1'b1;
    hs_addr   = 10'h3F0;
    hs_wdata  = 8'h5A;
    cpu_we    = 1'b0;
    cpu_addr  = 10'h011;
    cpu_wdata = 8'h22;
    #1;
    chk("own_before_reset_grant", 16'(hs_grant), 16'd1);
    chk("own_before_reset_we",    16'(ram_we),   16'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_grant", 16'(hs_grant),  16'd0);
    chk("async_rst_pause", 16'(pause_cpu), 16'd0);
    chk("async_rst_we",    16'(ram_we),    16'(cpu_we));
    chk("async_rst_addr",  16'(ram_addr),  16'h011);
    chk("async_rst_state", 16'(dbg_state), 16'd0);
    hs_req = 1'b0;
    hs_we  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) idle_cycle();
    step();
    step();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL leftover_expectations: got %0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
